// File: rtl/cache_replacement.sv
// Replacement-state unit for a set-associative cache: NMRU, tree-PLRU or LFSR-random victim
// selection per line, with invalid ways always preferred over the policy choice.
module cache_replacement #(
  parameter int num_ways      = 4,
  parameter int lines_per_set = 16,
  parameter int mode          = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(lines_per_set)-1:0] index_lo,
  input  logic                             cache_replacement_update,
  input  logic [num_ways-1:0]              hit_vector,
  input  logic [num_ways-1:0]              valid_vector,
  output logic [num_ways-1:0]              cache_replacement_select,
  output logic [$clog2(num_ways)-1:0]      cache_replacement_index
);

  localparam int iw = $clog2(lines_per_set);
  localparam int wb = $clog2(num_ways);

  logic [iw-1:0] index;
  logic [wb-1:0] acc_way;
  logic [wb-1:0] policy_way;
  logic [wb-1:0] victim;
  logic          wr_en;

  always_ff @(posedge clk) begin
    if (rst) index <= '0;
    else     index <= index_lo;
  end

  assign wr_en = cache_replacement_update && (|hit_vector);

  // Lowest set bit of the hit vector is the accessed way
  always_comb begin
    acc_way = '0;
    for (int i = num_ways - 1; i >= 0; i--)
      if (hit_vector[i]) acc_way = wb'(i);
  end

  generate
    if (mode == 0) begin : g_nmru
      logic [num_ways-1:0] mru [lines_per_set];
      logic [num_ways-1:0] cur;

      assign cur = mru[index];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int l = 0; l < lines_per_set; l++) mru[l] <= '0;
        end else if (wr_en) begin
          mru[index] <= num_ways'(1) << acc_way;
        end
      end

      // Empty MRU falls through to way 0
      always_comb begin
        policy_way = '0;
        for (int i = 0; i < num_ways; i++)
          if (cur[i]) policy_way = wb'((i + 1) % num_ways);
      end
    end else if (mode == 1) begin : g_plru
      logic [num_ways-2:0] tree [lines_per_set];
      logic [num_ways-2:0] cur;
      logic [num_ways-2:0] nxt;

      assign cur = tree[index];

      // Heap walk: node k has children 2k+1 (lower) and 2k+2 (upper)
      always_comb begin
        int  node;
        logic b;
        node       = 0;
        policy_way = '0;
        for (int lvl = 0; lvl < wb; lvl++) begin
          b = 1'b0;
          for (int k = 0; k < num_ways - 1; k++)
            if (k == node) b = cur[k];
          policy_way[wb-1-lvl] = b;
          node = 2 * node + 1 + (b ? 1 : 0);
        end
      end

      always_comb begin
        int  node;
        logic b;
        node = 0;
        nxt  = cur;
        for (int lvl = 0; lvl < wb; lvl++) begin
          b = acc_way[wb-1-lvl];
          for (int k = 0; k < num_ways - 1; k++)
            if (k == node) nxt[k] = ~b;
          node = 2 * node + 1 + (b ? 1 : 0);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int l = 0; l < lines_per_set; l++) tree[l] <= '0;
        end else if (wr_en) begin
          tree[index] <= nxt;
        end
      end
    end else begin : g_rand
      logic [15:0] lfsr;
      logic        unused_rand;

      // Galois form of x^16+x^14+x^13+x^11+1, shifting right
      always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'h0001;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end

      assign policy_way  = lfsr[wb-1:0];
      assign unused_rand = ^{index, acc_way, wr_en};
    end
  endgenerate

  always_comb begin
    victim = policy_way;
    for (int i = num_ways - 1; i >= 0; i--)
      if (!valid_vector[i]) victim = wb'(i);
  end

  assign cache_replacement_select = num_ways'(1) << victim;
  assign cache_replacement_index  = victim;

endmodule

// File: tb/tb_cache_replacement.sv
// Scoreboard bench: one DUT per policy on shared stimulus, checked against an abstract
// per-line model (MRU way number, tree bit array, LFSR value).
module tb_cache_replacement;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] index_lo = '0;
  logic       update = 1'b0;
  logic [3:0] hit_vector = '0;
  logic [3:0] valid_vector = 4'hF;
  logic [3:0] sel0, sel1, sel2;
  logic [1:0] idx0, idx1, idx2;

  always #5 clk = ~clk;

  cache_replacement #(.num_ways(4), .lines_per_set(16), .mode(0)) u_nmru (
    .clk(clk), .rst(rst), .index_lo(index_lo), .cache_replacement_update(update),
    .hit_vector(hit_vector), .valid_vector(valid_vector),
    .cache_replacement_select(sel0), .cache_replacement_index(idx0));

  cache_replacement #(.num_ways(4), .lines_per_set(16), .mode(1)) u_plru (
    .clk(clk), .rst(rst), .index_lo(index_lo), .cache_replacement_update(update),
    .hit_vector(hit_vector), .valid_vector(valid_vector),
    .cache_replacement_select(sel1), .cache_replacement_index(idx1));

  cache_replacement #(.num_ways(4), .lines_per_set(16), .mode(2)) u_rand (
    .clk(clk), .rst(rst), .index_lo(index_lo), .cache_replacement_update(update),
    .hit_vector(hit_vector), .valid_vector(valid_vector),
    .cache_replacement_select(sel2), .cache_replacement_index(idx2));

  typedef struct packed {
    logic [3:0] s0, s1, s2;
    logic [1:0] i0, i1, i2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  int          m_index;
  int          mru [16];
  int          tree [16][3];
  logic [15:0] m_lfsr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int w);
    return 4'(1 << w);
  endfunction

  task automatic push_expected(input logic [3:0] valid);
    int   inv, v0, v1, v2;
    exp_t e;
    inv = -1;
    for (int i = 3; i >= 0; i--) if (!valid[i]) inv = i;
    v0 = (mru[m_index] < 0) ? 0 : (mru[m_index] + 1) % 4;
    v1 = 0;
    for (int lvl = 0; lvl < 2; lvl++) v1 = v1 * 2 + tree[m_index][(1 << lvl) - 1 + v1];
    v2 = int'(m_lfsr) % 4;
    if (inv >= 0) begin
      v0 = inv; v1 = inv; v2 = inv;
    end
    e.s0 = onehot(v0); e.i0 = 2'(v0);
    e.s1 = onehot(v1); e.i1 = 2'(v1);
    e.s2 = onehot(v2); e.i2 = 2'(v2);
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input logic r, input int nidx, input logic upd, input logic [3:0] hit);
    int w;
    if (r) begin
      for (int l = 0; l < 16; l++) begin
        mru[l] = -1;
        for (int n = 0; n < 3; n++) tree[l][n] = 0;
      end
      m_index = 0;
      m_lfsr  = 16'h0001;
    end else begin
      if (upd && hit != 4'b0000) begin
        w = 0;
        for (int i = 3; i >= 0; i--) if (hit[i]) w = i;
        mru[m_index] = w;
        for (int lvl = 0; lvl < 2; lvl++)
          tree[m_index][(1 << lvl) - 1 + (w >> (2 - lvl))] = ((w >> (1 - lvl)) & 1) ? 0 : 1;
      end
      m_index = nidx;
      m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  endtask

  // Inputs apply for one cycle; expected outputs for that cycle are queued first
  task automatic step(input logic r, input int nidx, input logic upd,
                      input logic [3:0] hit, input logic [3:0] valid);
    rst          = r;
    index_lo     = 4'(nidx);
    update       = upd;
    hit_vector   = hit;
    valid_vector = valid;
    if (!r) push_expected(valid);
    @(posedge clk);
    model_edge(r, nidx, upd, hit);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("nmru_select", int'(sel0), int'(e.s0));
      chk("nmru_index",  int'(idx0), int'(e.i0));
      chk("plru_select", int'(sel1), int'(e.s1));
      chk("plru_index",  int'(idx1), int'(e.i1));
      chk("rand_select", int'(sel2), int'(e.s2));
      chk("rand_index",  int'(idx2), int'(e.i2));
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(1, 0, 0, 4'b0000, 4'hF);
    step(1, 0, 0, 4'b0000, 4'hF);

    // NMRU advance and wrap on line 2
    step(0, 2, 0, 4'b0000, 4'hF);
    step(0, 2, 1, 4'b0100, 4'hF);
    step(0, 2, 1, 4'b1000, 4'hF);
    step(0, 2, 0, 4'b0000, 4'hF);

    // PLRU sequence on line 5
    step(0, 5, 0, 4'b0000, 4'hF);
    step(0, 5, 1, 4'b0001, 4'hF);
    step(0, 5, 1, 4'b0010, 4'hF);
    step(0, 5, 1, 4'b0100, 4'hF);
    step(0, 5, 1, 4'b1000, 4'hF);
    step(0, 5, 1, 4'b0001, 4'hF);
    step(0, 5, 0, 4'b0000, 4'hF);

    // Invalid override, empty hit vector, multi-hit
    step(0, 5, 0, 4'b0000, 4'b1011);
    step(0, 5, 1, 4'b0000, 4'b1011);
    step(0, 5, 1, 4'b0110, 4'hF);
    step(0, 5, 0, 4'b0000, 4'hF);

    // Line isolation: hammer line 3, then read line 7
    step(0, 3, 0, 4'b0000, 4'hF);
    for (int i = 0; i < 6; i++) step(0, 3, 1, 4'($urandom_range(1, 15)), 4'hF);
    step(0, 7, 0, 4'b0000, 4'hF);
    step(0, 7, 0, 4'b0000, 4'hF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0, int'($urandom_range(0, 15)), 1'($urandom),
           4'($urandom), (($urandom % 4) == 0) ? 4'($urandom) : 4'hF);
    end

    // Updates across lines, reset carrying a dropped update, then sweep every line
    for (int l = 0; l < 16; l++) step(0, l, 1, 4'($urandom_range(1, 15)), 4'hF);
    step(1, 9, 1, 4'b0010, 4'hF);
    for (int l = 0; l < 16; l++) step(0, l, 0, 4'b0000, 4'hF);
    step(0, 0, 0, 4'b0000, 4'hF);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
